// File: rtl/midi_pkg.sv
// Shared constants, parser state type and status-byte data-count helper for the MIDI parser.
package midi_pkg;

  localparam logic [7:0] NOTE_OFF    = 8'h80;
  localparam logic [7:0] NOTE_ON     = 8'h90;
  localparam logic [7:0] SYSEX_START = 8'hF0;
  localparam logic [7:0] SYSEX_END   = 8'hF7;
  localparam logic [7:0] TUNE_REQ    = 8'hF6;
  localparam logic [7:0] RT_MIN      = 8'hF8;
  localparam logic [7:0] UNDEF_F4    = 8'hF4;
  localparam logic [7:0] UNDEF_F5    = 8'hF5;

  typedef enum logic [1:0] {
    StIdle,
    StWaitD1,
    StWaitD2,
    StSysex
  } parse_state_e;

  // Number of data bytes that follow a status byte (0 for anything without data).
  function automatic logic [1:0] data_len(input logic [7:0] status);
    logic [1:0] len;
    len = 2'd0;
    case (status[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd2;
      4'hC, 4'hD:                   len = 2'd1;
      4'hF: begin
        case (status[3:0])
          4'h1, 4'h3: len = 2'd1;
          4'h2:       len = 2'd2;
          default:    len = 2'd0;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/midi_data_len.sv
// Combinational classifier: data count and category flags for a status byte.
module midi_data_len
  import midi_pkg::*;
(
  input  logic [7:0] status_i,
  output logic [1:0] len_o,
  output logic       is_realtime_o,
  output logic       is_sysex_o,
  output logic       is_undefined_o
);

  // Decode the byte into its data count and category flags.
  always_comb begin
    len_o          = data_len(status_i);
    is_realtime_o  = (status_i >= RT_MIN);
    is_sysex_o     = (status_i == SYSEX_START);
    is_undefined_o = (status_i == UNDEF_F4) || (status_i == UNDEF_F5);
  end

endmodule

// File: rtl/midi_msg_parser.sv
// MIDI byte-stream parser: assembles channel/system-common messages with running status,
// skips SysEx, passes or drops realtime bytes, and flags dropped or abandoned input.
module midi_msg_parser
  import midi_pkg::*;
#(
  parameter bit PASS_REALTIME    = 1'b1,
  parameter bit NOTEON_V0_AS_OFF = 1'b1
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic [7:0]  RX_BYTE,
  input  logic        RX_BYTE_RDY,
  output logic [23:0] MIDI_MSG,
  output logic        MIDI_MSG_RDY,
  output logic        PARSE_ERR
);

  parse_state_e state_q, state_d;
  logic [7:0]   rs_q, rs_d;        // running status, 0 = none
  logic [7:0]   cur_q, cur_d;      // status of the message being assembled
  logic [1:0]   len_q, len_d;      // data count of cur_q
  logic [7:0]   d1_q, d1_d;
  logic         partial_q, partial_d;  // bytes received since the last emission
  logic [23:0]  msg_q, msg_d;
  logic         rdy_q, rdy_d;
  logic         err_q, err_d;

  logic [1:0]   rx_len;
  logic         rx_is_rt, rx_is_sysex, rx_is_undef;

  midi_data_len u_data_len (
    .status_i       (RX_BYTE),
    .len_o          (rx_len),
    .is_realtime_o  (rx_is_rt),
    .is_sysex_o     (rx_is_sysex),
    .is_undefined_o (rx_is_undef)
  );

  // Next-state, message assembly and output pulse decode for one received byte.
  always_comb begin
    state_d   = state_q;
    rs_d      = rs_q;
    cur_d     = cur_q;
    len_d     = len_q;
    d1_d      = d1_q;
    partial_d = partial_q;
    msg_d     = msg_q;
    rdy_d     = 1'b0;
    err_d     = 1'b0;

    if (RX_BYTE_RDY) begin
      if (!RX_BYTE[7]) begin
        unique case (state_q)
          StIdle:  err_d = 1'b1;
          StSysex: ;
          StWaitD1: begin
            if (len_q == 2'd2) begin
              d1_d      = RX_BYTE;
              partial_d = 1'b1;
              state_d   = StWaitD2;
            end else begin
              msg_d     = {cur_q, RX_BYTE, 8'h00};
              rdy_d     = 1'b1;
              partial_d = 1'b0;
              state_d   = (rs_q != 8'h00) ? StWaitD1 : StIdle;
            end
          end
          StWaitD2: begin
            msg_d = {cur_q, d1_q, RX_BYTE};
            if (NOTEON_V0_AS_OFF && (cur_q[7:4] == NOTE_ON[7:4]) && (RX_BYTE == 8'h00)) begin
              msg_d[23:20] = NOTE_OFF[7:4];
            end
            rdy_d     = 1'b1;
            partial_d = 1'b0;
            state_d   = (rs_q != 8'h00) ? StWaitD1 : StIdle;
          end
        endcase
      end else if (rx_is_rt) begin
        // Realtime bytes are transparent to the parse in progress.
        if (PASS_REALTIME) begin
          msg_d = {RX_BYTE, 16'h0000};
          rdy_d = 1'b1;
        end
      end else if (RX_BYTE == SYSEX_END) begin
        if (state_q == StSysex) begin
          state_d = StIdle;
        end
      end else begin
        // New status: any half-built message is abandoned.
        if ((state_q == StWaitD2) || ((state_q == StWaitD1) && partial_q)) begin
          err_d = 1'b1;
        end
        partial_d = 1'b0;
        rs_d      = 8'h00;
        if (RX_BYTE < SYSEX_START) begin
          rs_d      = RX_BYTE;
          cur_d     = RX_BYTE;
          len_d     = rx_len;
          partial_d = 1'b1;
          state_d   = StWaitD1;
        end else if (rx_is_sysex) begin
          state_d = StSysex;
        end else if (rx_is_undef) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else if (RX_BYTE == TUNE_REQ) begin
          msg_d   = {TUNE_REQ, 16'h0000};
          rdy_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cur_d     = RX_BYTE;
          len_d     = rx_len;
          partial_d = 1'b1;
          state_d   = StWaitD1;
        end
      end
    end
  end

  // Parser state and registered outputs.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q   <= StIdle;
      rs_q      <= 8'h00;
      cur_q     <= 8'h00;
      len_q     <= 2'd0;
      d1_q      <= 8'h00;
      partial_q <= 1'b0;
      msg_q     <= 24'h000000;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      rs_q      <= rs_d;
      cur_q     <= cur_d;
      len_q     <= len_d;
      d1_q      <= d1_d;
      partial_q <= partial_d;
      msg_q     <= msg_d;
      rdy_q     <= rdy_d;
      err_q     <= err_d;
    end
  end

  assign MIDI_MSG     = msg_q;
  assign MIDI_MSG_RDY = rdy_q;
  assign PARSE_ERR    = err_q;

endmodule

// File: tb/tb_midi_msg_parser.sv
// Bench for midi_msg_parser: two DUTs (realtime pass + note-on rewrite on / both off) fed the
// same bytes and compared every cycle against a message-level reference model.
module tb_midi_msg_parser;

  logic        clk;
  logic        rst_n;
  logic [7:0]  rx_byte;
  logic        rx_rdy;
  logic [23:0] msg_a, msg_b;
  logic        rdy_a, rdy_b, err_a, err_b;

  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  midi_msg_parser #(.PASS_REALTIME(1'b1), .NOTEON_V0_AS_OFF(1'b1)) u_dut_a (
    .CLK          (clk),
    .nRST         (rst_n),
    .RX_BYTE      (rx_byte),
    .RX_BYTE_RDY  (rx_rdy),
    .MIDI_MSG     (msg_a),
    .MIDI_MSG_RDY (rdy_a),
    .PARSE_ERR    (err_a)
  );

  midi_msg_parser #(.PASS_REALTIME(1'b0), .NOTEON_V0_AS_OFF(1'b0)) u_dut_b (
    .CLK          (clk),
    .nRST         (rst_n),
    .RX_BYTE      (rx_byte),
    .RX_BYTE_RDY  (rx_rdy),
    .MIDI_MSG     (msg_b),
    .MIDI_MSG_RDY (rdy_b),
    .PARSE_ERR    (err_b)
  );

  // Reference model: pending status plus a queue of collected data bytes.
  logic [7:0]  m_run;
  logic [7:0]  m_stat;
  logic [7:0]  m_data[$];
  bit          m_sysex;
  bit          m_fresh;
  logic [23:0] e_msg_a, e_msg_b;
  logic        e_rdy_a, e_rdy_b, e_err;

  function automatic int need(input logic [7:0] s);
    if (s < 8'hC0) return 2;
    if (s < 8'hE0) return 1;
    if (s < 8'hF0) return 2;
    if (s == 8'hF1 || s == 8'hF3) return 1;
    if (s == 8'hF2) return 2;
    return 0;
  endfunction

  task automatic model_reset();
    m_run = 8'h00; m_stat = 8'h00; m_data.delete(); m_sysex = 0; m_fresh = 0;
    e_msg_a = 24'h0; e_msg_b = 24'h0; e_rdy_a = 0; e_rdy_b = 0; e_err = 0;
  endtask

  task automatic emit(input logic [23:0] raw, input bit note);
    e_rdy_a = 1; e_rdy_b = 1; e_msg_a = raw; e_msg_b = raw;
    if (note && raw[23:20] == 4'h9 && raw[7:0] == 8'h00) e_msg_a[23:20] = 4'h8;
  endtask

  task automatic model(input logic [7:0] b);
    logic [7:0] d0, d1;
    e_rdy_a = 0; e_rdy_b = 0; e_err = 0;
    if (b >= 8'hF8) begin
      e_rdy_a = 1; e_msg_a = {b, 16'h0};
    end else if (b < 8'h80) begin
      if (m_sysex) begin
      end else if (m_stat == 8'h00) begin
        e_err = 1;
      end else begin
        m_data.push_back(b);
        if (m_data.size() == need(m_stat)) begin
          d0 = m_data[0];
          d1 = (m_data.size() == 2) ? m_data[1] : 8'h00;
          emit({m_stat, d0, d1}, m_data.size() == 2);
          m_data.delete();
          m_fresh = 0;
          if (m_run == 8'h00) m_stat = 8'h00;
        end
      end
    end else if (b == 8'hF7) begin
      m_sysex = 0;
    end else begin
      if (!m_sysex && m_stat != 8'h00 && (m_fresh || m_data.size() > 0)) e_err = 1;
      m_data.delete(); m_sysex = 0; m_fresh = 0; m_stat = 8'h00; m_run = 8'h00;
      if (b < 8'hF0) begin
        m_stat = b; m_run = b; m_fresh = 1;
      end else if (b == 8'hF0) begin
        m_sysex = 1;
      end else if (b == 8'hF4 || b == 8'hF5) begin
        e_err = 1;
      end else if (b == 8'hF6) begin
        emit(24'hF60000, 0);
      end else begin
        m_stat = b; m_fresh = 1;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string ctx);
    chk({ctx, ".rdy_a"}, {23'h0, rdy_a}, {23'h0, e_rdy_a});
    chk({ctx, ".rdy_b"}, {23'h0, rdy_b}, {23'h0, e_rdy_b});
    chk({ctx, ".err_a"}, {23'h0, err_a}, {23'h0, e_err});
    chk({ctx, ".err_b"}, {23'h0, err_b}, {23'h0, e_err});
    chk({ctx, ".msg_a"}, msg_a, e_msg_a);
    chk({ctx, ".msg_b"}, msg_b, e_msg_b);
  endtask

  task automatic send(input logic [7:0] b, input string ctx);
    model(b);
    rx_byte = b;
    rx_rdy  = 1'b1;
    @(posedge clk); #1;
    rx_rdy  = 1'b0;
    check_all($sformatf("%s.%h", ctx, b));
  endtask

  task automatic idle(input string ctx);
    rx_rdy  = 1'b0;
    rx_byte = 8'($urandom);
    e_rdy_a = 0; e_rdy_b = 0; e_err = 0;
    @(posedge clk); #1;
    check_all({ctx, ".idle"});
  endtask

  task automatic do_reset(input string ctx);
    rx_rdy = 1'b0;
    rst_n  = 1'b0;
    model_reset();
    #1;
    check_all({ctx, ".rst_async"});
    @(posedge clk); #1;
    check_all({ctx, ".rst_hold"});
    rst_n = 1'b1;
  endtask

  initial begin
    logic [7:0] b;
    int r;
    rx_rdy = 1'b0; rx_byte = 8'h00; rst_n = 1'b1;
    model_reset();
    #2;
    do_reset("init");

    // Single note-on, then running status with velocity-0 rewrite.
    send(8'h90, "n1"); send(8'h3C, "n1"); send(8'h64, "n1");
    chk("n1.lit", msg_a, 24'h903C64);
    send(8'h40, "rs"); send(8'h7F, "rs");
    chk("rs.lit", msg_a, 24'h90407F);
    send(8'h3C, "v0"); send(8'h00, "v0");
    chk("v0.lit_a", msg_a, 24'h803C00);
    chk("v0.lit_b", msg_b, 24'h903C00);
    send(8'h3C, "rs2"); send(8'h01, "rs2");
    chk("rs2.lit", msg_a, 24'h903C01);
    idle("n1");

    // Realtime interleaved in a message.
    send(8'h90, "rt"); send(8'h3C, "rt"); send(8'hF8, "rt");
    chk("rt.lit_a", msg_a, 24'hF80000);
    send(8'h64, "rt");
    chk("rt.lit_b", msg_b, 24'h903C64);

    // SysEx skip, then program change.
    send(8'hF0, "sx"); send(8'h7E, "sx"); send(8'h01, "sx"); send(8'hF7, "sx");
    send(8'hC5, "sx"); send(8'h07, "sx");
    chk("sx.lit", msg_a, 24'hC50700);

    // Orphan data bytes.
    do_reset("orph");
    send(8'h12, "orph"); send(8'h45, "orph");

    // Abandoned message, then running status of the new status.
    send(8'hB0, "ab"); send(8'h07, "ab"); send(8'h80, "ab");
    send(8'h40, "ab"); send(8'h00, "ab");
    chk("ab.lit", msg_a, 24'h804000);

    // Reset mid-message.
    send(8'h90, "mr"); send(8'h3C, "mr");
    do_reset("mr");
    send(8'h64, "mr");
    chk("mr.lit", msg_a, 24'h000000);

    // System common and tune request.
    send(8'hF2, "sc"); send(8'h11, "sc"); send(8'h22, "sc");
    send(8'h33, "sc");
    send(8'hF6, "sc"); send(8'hF4, "sc"); send(8'hF3, "sc"); send(8'h05, "sc");

    // Randomized byte stream with idle gaps and occasional reset.
    for (int i = 0; i < 1500; i++) begin
      r = int'($urandom_range(0, 99));
      if (r < 50)      b = 8'($urandom_range(8'h00, 8'h7F));
      else if (r < 75) b = 8'($urandom_range(8'h80, 8'hEF));
      else if (r < 87) b = 8'($urandom_range(8'hF0, 8'hF7));
      else             b = 8'($urandom_range(8'hF8, 8'hFF));
      send(b, "rnd");
      r = int'($urandom_range(0, 99));
      if (r < 15) idle("rnd");
      else if (r == 99) do_reset("rnd");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
